// File: rtl/multicycle_ctl_if.sv
// Control bus between the multicycle controller and the RV64 datapath.
// The controller is the master: it samples the opcode and memory handshake
// and drives every datapath strobe and mux select.
interface multicycle_ctl_if;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       PCSource;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegWrite;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp
  );
endinterface

// File: rtl/multicycle_ctl.sv
// Main control FSM for the multicycle RV64 datapath (add/sub/and/or, ld, sd, beq).
// Control outputs are registered decodes of the next state, so they line up with
// state_q exactly like a Moore decode. FETCH IRWrite/PCWrite are additionally
// qualified by mem_ready, and all strobes are forced low while rst_n is asserted.
module multicycle_ctl #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_ctl_if.master     bus,
  output logic [3:0]           state_o,
  output logic                 halted,
  output logic [1:0]           fault,
  output logic [CNT_W-1:0]     instr_count
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
  localparam logic [WaitW-1:0] TimeoutC = WaitW'(TIMEOUT);

  localparam logic [6:0] OpRType = 7'b0110011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpBeq   = 7'b1100011;

  localparam logic [1:0] FaultNone    = 2'b00;
  localparam logic [1:0] FaultIllegal = 2'b01;
  localparam logic [1:0] FaultTimeout = 2'b10;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StRwb    = 4'd7,
    StBranch = 4'd8,
    StTrap   = 4'd15
  } state_e;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       pcsource;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regwrite;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       halted;
  } ctl_t;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d, wait_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       fault_q, fault_d;
  logic             retire;
  logic             timed_out;
  ctl_t             ctl_q;

  // Moore output table; pcwrite/irwrite in FETCH are later gated by mem_ready.
  function automatic ctl_t decode(state_e s);
    ctl_t c;
    c = '0;
    case (s)
      StFetch: begin
        c.memread = 1'b1;
        c.pcwrite = 1'b1;
        c.irwrite = 1'b1;
        c.alusrcb = 2'b01;
      end
      StDecode: begin
        c.alusrca = 2'b01;
        c.alusrcb = 2'b10;
      end
      StMemAdr: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b10;
      end
      StMemRd: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      StMemWb: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      StMemWr: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      StExec: begin
        c.alusrca = 2'b10;
        c.aluop   = 2'b10;
      end
      StRwb: c.regwrite = 1'b1;
      StBranch: begin
        c.alusrca     = 2'b10;
        c.aluop       = 2'b01;
        c.pcwritecond = 1'b1;
        c.pcsource    = 1'b1;
      end
      StTrap:  c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state, wait-counter, fault and retire logic.
  always_comb begin
    state_d   = state_q;
    fault_d   = fault_q;
    wait_d    = wait_q;
    cnt_d     = cnt_q;
    retire    = 1'b0;
    wait_inc  = wait_q + WaitW'(1);
    // Only meaningful in the three waiting states; ready in the same cycle wins.
    timed_out = !bus.mem_ready && (wait_inc == TimeoutC);

    case (state_q)
      StFetch: begin
        if (bus.mem_ready) begin
          state_d = StDecode;
        end else if (timed_out) begin
          state_d = StTrap;
          fault_d = FaultTimeout;
        end else begin
          wait_d = wait_inc;
        end
      end
      StDecode: begin
        case (bus.opcode)
          OpRType:         state_d = StExec;
          OpLoad, OpStore: state_d = StMemAdr;
          OpBeq:           state_d = StBranch;
          default: begin
            state_d = StTrap;
            fault_d = FaultIllegal;
          end
        endcase
      end
      StMemAdr: state_d = (bus.opcode == OpStore) ? StMemWr : StMemRd;
      StMemRd: begin
        if (bus.mem_ready) begin
          state_d = StMemWb;
        end else if (timed_out) begin
          state_d = StTrap;
          fault_d = FaultTimeout;
        end else begin
          wait_d = wait_inc;
        end
      end
      StMemWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StMemWr: begin
        if (bus.mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end else if (timed_out) begin
          state_d = StTrap;
          fault_d = FaultTimeout;
        end else begin
          wait_d = wait_inc;
        end
      end
      StExec: state_d = StRwb;
      StRwb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StBranch: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StTrap: state_d = StTrap;
      default: begin
        // Unused encodings 9-14 are treated as a corrupted instruction flow.
        state_d = StTrap;
        fault_d = FaultIllegal;
      end
    endcase

    // Every waiting state starts its budget from zero on entry.
    if (state_d != state_q) begin
      wait_d = '0;
    end
    if (retire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State register plus registered decode of the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      wait_q  <= '0;
      cnt_q   <= '0;
      fault_q <= FaultNone;
      ctl_q   <= decode(StFetch);
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      ctl_q   <= decode(state_d);
    end
  end

  // Drive the bus; rst_n gating keeps strobes low during reset even though FETCH decodes them.
  always_comb begin
    bus.PCWrite     = ctl_q.pcwrite & bus.mem_ready & rst_n;
    bus.IRWrite     = ctl_q.irwrite & bus.mem_ready & rst_n;
    bus.PCWriteCond = ctl_q.pcwritecond & rst_n;
    bus.PCSource    = ctl_q.pcsource & rst_n;
    bus.IorD        = ctl_q.iord & rst_n;
    bus.MemRead     = ctl_q.memread & rst_n;
    bus.MemWrite    = ctl_q.memwrite & rst_n;
    bus.MemtoReg    = ctl_q.memtoreg & rst_n;
    bus.RegWrite    = ctl_q.regwrite & rst_n;
    bus.ALUSrcA     = ctl_q.alusrca & {2{rst_n}};
    bus.ALUSrcB     = ctl_q.alusrcb & {2{rst_n}};
    bus.ALUOp       = ctl_q.aluop & {2{rst_n}};
  end

  assign state_o     = state_q;
  assign halted      = ctl_q.halted;
  assign fault       = fault_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_ctl.sv
// Scoreboard bench for multicycle_ctl. Stimulus pushes the expected per-cycle
// outputs into a queue; a monitor on the falling edge pops and compares.
// u_main uses default parameters; u_small (TIMEOUT=4, CNT_W=2) covers the
// fetch timeout and counter wrap.
module tb_multicycle_ctl;

  localparam logic [6:0] ADD = 7'b0110011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] SD  = 7'b0100011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  // {PCWrite,PCWriteCond,PCSource,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegWrite},
  // ALUSrcA, ALUSrcB, ALUOp
  localparam logic [14:0] K_ZERO    = 15'b0;
  localparam logic [14:0] K_FETCH_W = {9'b000010000, 2'd0, 2'd1, 2'd0};
  localparam logic [14:0] K_FETCH_R = {9'b100010100, 2'd0, 2'd1, 2'd0};
  localparam logic [14:0] K_DECODE  = {9'b000000000, 2'd1, 2'd2, 2'd0};
  localparam logic [14:0] K_MEMADR  = {9'b000000000, 2'd2, 2'd2, 2'd0};
  localparam logic [14:0] K_MEMRD   = {9'b000110000, 2'd0, 2'd0, 2'd0};
  localparam logic [14:0] K_MEMWB   = {9'b000000011, 2'd0, 2'd0, 2'd0};
  localparam logic [14:0] K_MEMWR   = {9'b000101000, 2'd0, 2'd0, 2'd0};
  localparam logic [14:0] K_EXEC    = {9'b000000000, 2'd2, 2'd0, 2'd2};
  localparam logic [14:0] K_RWB     = {9'b000000001, 2'd0, 2'd0, 2'd0};
  localparam logic [14:0] K_BRANCH  = {9'b011000000, 2'd2, 2'd0, 2'd1};

  typedef struct {
    int          d;
    logic [3:0]  st;
    logic [14:0] ctl;
    logic        h;
    logic [1:0]  f;
    logic [31:0] cnt;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n0, rst_n1;
  logic [3:0]  st0, st1;
  logic        h0, h1;
  logic [1:0]  f0, f1;
  logic [31:0] cnt0;
  logic [1:0]  cnt1;

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  multicycle_ctl_if if0 ();
  multicycle_ctl_if if1 ();

  multicycle_ctl u_main (
    .clk         (clk),
    .rst_n       (rst_n0),
    .bus         (if0),
    .state_o     (st0),
    .halted      (h0),
    .fault       (f0),
    .instr_count (cnt0)
  );

  multicycle_ctl #(.CNT_W(2), .TIMEOUT(4)) u_small (
    .clk         (clk),
    .rst_n       (rst_n1),
    .bus         (if1),
    .state_o     (st1),
    .halted      (h1),
    .fault       (f1),
    .instr_count (cnt1)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus on DUT d and queue the outputs expected in that cycle.
  task automatic cyc(input int d, input logic rst, input logic [6:0] opc, input logic rdy,
                     input logic [3:0] st, input logic [14:0] ctl, input logic h,
                     input logic [1:0] f, input logic [31:0] cnt, input string name);
    exp_t e;
    if (d == 0) begin
      rst_n0 = rst; if0.opcode = opc; if0.mem_ready = rdy;
    end else begin
      rst_n1 = rst; if1.opcode = opc; if1.mem_ready = rdy;
    end
    e.d = d; e.st = st; e.ctl = ctl; e.h = h; e.f = f; e.cnt = cnt; e.name = name;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  // Monitor: compare every queued expectation against the DUT mid-cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [3:0]  a_st;
      logic [14:0] a_ctl;
      logic        a_h;
      logic [1:0]  a_f;
      logic [31:0] a_cnt;
      e = q.pop_front();
      if (e.d == 0) begin
        a_st = st0; a_h = h0; a_f = f0; a_cnt = cnt0;
        a_ctl = {if0.PCWrite, if0.PCWriteCond, if0.PCSource, if0.IorD, if0.MemRead,
                 if0.MemWrite, if0.IRWrite, if0.MemtoReg, if0.RegWrite,
                 if0.ALUSrcA, if0.ALUSrcB, if0.ALUOp};
      end else begin
        a_st = st1; a_h = h1; a_f = f1; a_cnt = {30'b0, cnt1};
        a_ctl = {if1.PCWrite, if1.PCWriteCond, if1.PCSource, if1.IorD, if1.MemRead,
                 if1.MemWrite, if1.IRWrite, if1.MemtoReg, if1.RegWrite,
                 if1.ALUSrcA, if1.ALUSrcB, if1.ALUOp};
      end
      checks++;
      if (a_st !== e.st || a_ctl !== e.ctl || a_h !== e.h || a_f !== e.f
          || a_cnt !== e.cnt) begin
        errors++;
        $display("FAIL %s: got st=%0d ctl=%b halted=%b fault=%b cnt=%0d, want st=%0d ctl=%b halted=%b fault=%b cnt=%0d",
                 e.name, a_st, a_ctl, a_h, a_f, a_cnt, e.st, e.ctl, e.h, e.f, e.cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    if0.opcode = '0; if0.mem_ready = 1'b0;
    if1.opcode = '0; if1.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state: strobes gated even with mem_ready high
    cyc(0, 0, ADD, 1, 0, K_ZERO, 0, 2'd0, 0, "rst_state");

    // add with mem_ready tied high: 0,1,6,7
    cyc(0, 1, ADD, 1, 0, K_FETCH_R, 0, 2'd0, 0, "add_fetch");
    cyc(0, 1, ADD, 1, 1, K_DECODE,  0, 2'd0, 0, "add_decode");
    cyc(0, 1, ADD, 1, 6, K_EXEC,    0, 2'd0, 0, "add_exec");
    cyc(0, 1, ADD, 1, 7, K_RWB,     0, 2'd0, 0, "add_rwb");

    // ld with three wait cycles in MEMRD
    cyc(0, 1, LD, 1, 0, K_FETCH_R, 0, 2'd0, 1, "ld_fetch");
    cyc(0, 1, LD, 1, 1, K_DECODE,  0, 2'd0, 1, "ld_decode");
    cyc(0, 1, LD, 0, 2, K_MEMADR,  0, 2'd0, 1, "ld_memadr");
    for (int i = 0; i < 3; i++) cyc(0, 1, LD, 0, 3, K_MEMRD, 0, 2'd0, 1, "ld_memrd_wait");
    cyc(0, 1, LD, 1, 3, K_MEMRD,   0, 2'd0, 1, "ld_memrd_done");
    cyc(0, 1, LD, 1, 4, K_MEMWB,   0, 2'd0, 1, "ld_memwb");

    // sd (two wait cycles) then beq back-to-back
    cyc(0, 1, SD, 1, 0, K_FETCH_R, 0, 2'd0, 2, "sd_fetch");
    cyc(0, 1, SD, 1, 1, K_DECODE,  0, 2'd0, 2, "sd_decode");
    cyc(0, 1, SD, 0, 2, K_MEMADR,  0, 2'd0, 2, "sd_memadr");
    cyc(0, 1, SD, 0, 5, K_MEMWR,   0, 2'd0, 2, "sd_memwr_wait0");
    cyc(0, 1, SD, 0, 5, K_MEMWR,   0, 2'd0, 2, "sd_memwr_wait1");
    cyc(0, 1, SD, 1, 5, K_MEMWR,   0, 2'd0, 2, "sd_memwr_done");
    cyc(0, 1, BEQ, 1, 0, K_FETCH_R, 0, 2'd0, 3, "beq_fetch");
    cyc(0, 1, BEQ, 1, 1, K_DECODE,  0, 2'd0, 3, "beq_decode");
    cyc(0, 1, BEQ, 1, 8, K_BRANCH,  0, 2'd0, 3, "beq_branch");

    // Reset asserted mid-MEMWR: outputs drop within the same cycle
    cyc(0, 1, SD, 1, 0, K_FETCH_R, 0, 2'd0, 4, "sd2_fetch");
    cyc(0, 1, SD, 1, 1, K_DECODE,  0, 2'd0, 4, "sd2_decode");
    cyc(0, 1, SD, 0, 2, K_MEMADR,  0, 2'd0, 4, "sd2_memadr");
    cyc(0, 1, SD, 0, 5, K_MEMWR,   0, 2'd0, 4, "sd2_memwr");
    cyc(0, 0, SD, 0, 0, K_ZERO,    0, 2'd0, 0, "rst_mid_memwr");

    // One add to get a nonzero count, then an illegal opcode traps
    cyc(0, 1, ADD, 1, 0, K_FETCH_R, 0, 2'd0, 0, "add2_fetch");
    cyc(0, 1, ADD, 1, 1, K_DECODE,  0, 2'd0, 0, "add2_decode");
    cyc(0, 1, ADD, 1, 6, K_EXEC,    0, 2'd0, 0, "add2_exec");
    cyc(0, 1, ADD, 1, 7, K_RWB,     0, 2'd0, 0, "add2_rwb");
    cyc(0, 1, BAD, 1, 0, K_FETCH_R, 0, 2'd0, 1, "bad_fetch");
    cyc(0, 1, BAD, 1, 1, K_DECODE,  0, 2'd0, 1, "bad_decode");
    cyc(0, 1, BAD, 1, 15, K_ZERO,   1, 2'd1, 1, "trap_hold0");
    cyc(0, 1, ADD, 0, 15, K_ZERO,   1, 2'd1, 1, "trap_hold1");
    cyc(0, 1, LD,  1, 15, K_ZERO,   1, 2'd1, 1, "trap_hold2");
    cyc(0, 0, BAD, 1, 0, K_ZERO,    0, 2'd0, 0, "trap_reset");
    cyc(0, 1, ADD, 0, 0, K_FETCH_W, 0, 2'd0, 0, "post_trap_fetch");
    rst_n0 = 1'b0;

    // Fetch timeout (TIMEOUT=4): four FETCH cycles, no IRWrite/PCWrite, then TRAP
    for (int i = 0; i < 4; i++) cyc(1, 1, ADD, 0, 0, K_FETCH_W, 0, 2'd0, 0, "to_fetch");
    cyc(1, 1, ADD, 0, 15, K_ZERO, 1, 2'd2, 0, "to_trap0");
    cyc(1, 1, ADD, 1, 15, K_ZERO, 1, 2'd2, 0, "to_trap1");
    cyc(1, 0, ADD, 0, 0, K_ZERO,  0, 2'd0, 0, "small_reset");

    // Four adds on a 2-bit counter; the first also has ready arrive as the count hits TIMEOUT
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        for (int j = 0; j < 3; j++) cyc(1, 1, ADD, 0, 0, K_FETCH_W, 0, 2'd0, 0, "wrap_wait");
      end
      cyc(1, 1, ADD, 1, 0, K_FETCH_R, 0, 2'd0, 32'(i), "wrap_fetch");
      cyc(1, 1, ADD, 1, 1, K_DECODE,  0, 2'd0, 32'(i), "wrap_decode");
      cyc(1, 1, ADD, 1, 6, K_EXEC,    0, 2'd0, 32'(i), "wrap_exec");
      cyc(1, 1, ADD, 1, 7, K_RWB,     0, 2'd0, 32'(i), "wrap_rwb");
    end
    cyc(1, 1, ADD, 0, 0, K_FETCH_W, 0, 2'd0, 0, "wrap_to_zero");
    rst_n1 = 1'b0;

    @(negedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
